// File: rtl/wb_ahbl_pkg.sv
// Shared constants and FSM state type for the Wishbone-classic to AHB-Lite bridge.
package wb_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_sel_decode.sv
// Maps Wishbone byte selects to an AHB transfer size and byte offset within the word.
module wb_sel_decode
    import wb_ahbl_pkg::*;
(
    input  logic [3:0] sel,
    output logic [2:0] hsize,
    output logic [1:0] offset
);

    always_comb begin
        hsize  = HSIZE_WORD;
        offset = 2'd0;
        case (sel)
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
            4'b0001: hsize = HSIZE_BYTE;
            4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
            4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
            4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
            // Non-contiguous or empty selects fall back to a full word access.
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_ahbl_bridge.sv
// Single-outstanding Wishbone-classic slave to AHB-Lite master bridge.
// Optional HREADY watchdog enabled by defining WB_AHBL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for wbs_cyc_i & wbs_stb_i; request registered on accept
// ADDR    | HTRANS=NONSEQ, held until HREADY=1
// DATA    | HTRANS=IDLE, HWDATA driven, HRDATA captured when HREADY=1
// ACK     | one-cycle wbs_ack_o (suppressed if the WB cycle was dropped)
module wb_ahbl_bridge
    import wb_ahbl_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFF,
    parameter logic [31:0] AHB_BASE  = 32'h0000_0000
`ifdef WB_AHBL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
)(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
`ifdef WB_AHBL_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        abort_q, abort_d;
    logic        timeout_hit;

    logic [2:0]  sel_hsize;
    logic [1:0]  sel_off;

    wb_sel_decode u_sel_decode (
        .sel    (wbs_sel_i),
        .hsize  (sel_hsize),
        .offset (sel_off)
    );

`ifdef WB_AHBL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_q, tmo_d;

    // Down-counter reloads whenever the bus is ready or no transfer is pending.
    always_comb begin
        tmr_d       = TW'(TIMEOUT_CYCLES);
        timeout_hit = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_DATA) && !HREADY) begin
            tmr_d       = tmr_q - TW'(1);
            timeout_hit = (tmr_q == TW'(1));
        end
        tmo_d = tmo_q | timeout_hit;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmr_q <= TW'(TIMEOUT_CYCLES);
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        abort_d  = abort_q;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (wbs_cyc_i && wbs_stb_i) begin
                    haddr_d  = ((wbs_adr_i & ADDR_MASK & ~32'h3) | AHB_BASE)
                               | {30'd0, sel_off};
                    hsize_d  = sel_hsize;
                    hwrite_d = wbs_we_i;
                    hwdata_d = wbs_dat_i;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (timeout_hit) begin
                    if (!hwrite_q) rdata_d = DEADBEEF;
                    state_d = ST_ACK;
                end else if (HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // An AHB transfer cannot be aborted; a dropped cycle only hides the ack.
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (HREADY) begin
                    if (!hwrite_q) rdata_d = HRDATA;
                    state_d = ST_ACK;
                end else if (timeout_hit) begin
                    if (!hwrite_q) rdata_d = DEADBEEF;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            haddr_q  <= 32'd0;
            hsize_q  <= HSIZE_WORD;
            hwrite_q <= 1'b0;
            hwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            abort_q  <= abort_d;
        end
    end

    assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_q;
    assign HSIZE     = hsize_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign wbs_dat_o = rdata_q;
    assign wbs_ack_o = (state_q == ST_ACK) && !abort_q;

endmodule

// File: tb/tb_wb_ahbl_bridge.sv
// Testbench for wb_ahbl_bridge: vector table, random transfers against a transaction-level model,
// and hand sequences for reset, dropped cycle and (with WB_AHBL_TIMEOUT_EN) the HREADY timeout.
module tb_wb_ahbl_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
`ifdef WB_AHBL_TIMEOUT_EN
    logic        timeout_o;
`endif

    wb_ahbl_bridge #(
        .ADDR_MASK (32'h00FF_FFFF),
        .AHB_BASE  (32'h0000_0000)
`ifdef WB_AHBL_TIMEOUT_EN
        , .TIMEOUT_CYCLES (4)
`endif
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
`ifdef WB_AHBL_TIMEOUT_EN
        , .timeout_o (timeout_o)
`endif
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdat;
        int          wa;
        int          wd;
        logic [31:0] e_haddr;
        logic [2:0]  e_hsize;
        int          e_ack;
    } vec_t;

    vec_t        tbl[10];
    int          errors = 0;
    int          checks = 0;
    int          bad_htrans = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference mapping: one select -> byte at its lane, aligned pair -> half at its low lane, else word.
    function automatic void ref_map(input logic [3:0] sel, input logic [31:0] adr,
                                    output logic [31:0] a, output logic [2:0] sz);
        int ones = $countones(sel);
        int low = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
        a  = adr & 32'h00FF_FFFC;
        sz = 3'd2;
        if (ones == 1) begin
            sz = 3'd0;
            a  = a + 32'(low);
        end else if (ones == 2 && (sel == 4'b0011 || sel == 4'b1100)) begin
            sz = 3'd1;
            a  = a + 32'(low);
        end
    endfunction

    // Drives one WB request and acts as an AHB slave inserting wa address and wd data wait states.
    task automatic run_xfer(input vec_t v, output int ack_cyc, output int ns_cnt,
                            output logic [31:0] o_haddr, output logic [2:0] o_hsize,
                            output logic o_hwrite, output logic [31:0] o_hwdata,
                            output logic [31:0] o_rd);
        int aleft = v.wa;
        int dleft = v.wd;
        int phase = 0;
        ack_cyc = -1; ns_cnt = 0;
        o_haddr = 'x; o_hsize = 'x; o_hwrite = 'x; o_hwdata = 'x; o_rd = 'x;
        @(negedge HCLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
        wbs_sel_i = v.sel; wbs_adr_i = v.adr; wbs_dat_i = v.dat;
        HREADY = 1'b1; HRDATA = ~v.rdat;
        for (int n = 1; n <= 40; n++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b01 || HTRANS == 2'b11) bad_htrans++;
            if (wbs_ack_o) begin
                ack_cyc = n;
                o_rd    = wbs_dat_o;
                break;
            end
            if (phase == 1) begin
                if (dleft > 0) begin
                    HREADY = 1'b0; dleft--;
                end else begin
                    HREADY = 1'b1; HRDATA = v.rdat; o_hwdata = HWDATA; phase = 2;
                end
            end else if (HTRANS == 2'b10) begin
                ns_cnt++;
                o_haddr = HADDR; o_hsize = HSIZE; o_hwrite = HWRITE;
                if (aleft > 0) begin
                    HREADY = 1'b0; aleft--;
                end else begin
                    HREADY = 1'b1; phase = 1;
                end
            end else begin
                HREADY = 1'b1;
                HRDATA = ~v.rdat;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; HREADY = 1'b1; HRDATA = $urandom;
        @(negedge HCLK);
        chk("ack_single_pulse", {31'd0, wbs_ack_o}, 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          ack_c, ns;
        logic [31:0] ha, hw, rd, exp_rd;
        logic [2:0]  hs;
        logic        hwr;
        run_xfer(v, ack_c, ns, ha, hs, hwr, hw, rd);
        exp_rd = v.we ? last_rd : v.rdat;
        chk({tag, "_ack_cycle"}, ack_c, v.e_ack);
        chk({tag, "_nonseq_cycles"}, ns, 1 + v.wa);
        chk({tag, "_haddr"}, ha, v.e_haddr);
        chk({tag, "_hsize"}, {29'd0, hs}, {29'd0, v.e_hsize});
        chk({tag, "_hwrite"}, {31'd0, hwr}, {31'd0, v.we});
        if (v.we) chk({tag, "_hwdata"}, hw, v.dat);
        chk({tag, "_rdata"}, rd, exp_rd);
        last_rd = exp_rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    acks, ns;
        vec_t  v;
        logic [31:0] a;
        logic [2:0]  s;

        //            we    sel      adr            dat            rdat          wa wd haddr          hsize ack
        tbl[0] = '{1'b1, 4'b1111, 32'h3000_0010, 32'hA5A5_1234, 32'h0,         0, 0, 32'h0000_0010, 3'd2, 3};
        tbl[1] = '{1'b0, 4'b0100, 32'h3000_0020, 32'h0,         32'h00CC_0000, 0, 2, 32'h0000_0022, 3'd0, 5};
        tbl[2] = '{1'b0, 4'b1111, 32'h0000_1000, 32'h0,         32'h1234_5678, 3, 0, 32'h0000_1000, 3'd2, 6};
        tbl[3] = '{1'b1, 4'b1100, 32'h1234_5678, 32'hBEEF_0000, 32'h0,         0, 0, 32'h0034_567A, 3'd1, 3};
        tbl[4] = '{1'b1, 4'b0011, 32'h0000_0107, 32'h0000_C0DE, 32'h0,         1, 0, 32'h0000_0104, 3'd1, 4};
        tbl[5] = '{1'b0, 4'b1000, 32'h0000_0040, 32'h0,         32'h7700_0000, 0, 1, 32'h0000_0043, 3'd0, 4};
        tbl[6] = '{1'b1, 4'b0010, 32'h0000_0000, 32'h0000_5A00, 32'h0,         0, 0, 32'h0000_0001, 3'd0, 3};
        tbl[7] = '{1'b0, 4'b0000, 32'h0000_00FF, 32'h0,         32'hCAFE_F00D, 0, 0, 32'h0000_00FC, 3'd2, 3};
        tbl[8] = '{1'b0, 4'b0101, 32'h0000_0008, 32'h0,         32'h0102_0304, 1, 1, 32'h0000_0008, 3'd2, 5};
        tbl[9] = '{1'b1, 4'b0110, 32'hAB00_0013, 32'h0066_6600, 32'h0,         0, 0, 32'h0000_0010, 3'd2, 3};

        // Reset values
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat_o", wbs_dat_o, 32'd0);
`ifdef WB_AHBL_TIMEOUT_EN
        chk("rst_timeout_o", {31'd0, timeout_o}, 32'd0);
`endif
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < 10; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset in the data phase of a read: outputs clear at once, no ack, next transfer is clean.
        @(negedge HCLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0044; HREADY = 1'b1;
        @(negedge HCLK);
        chk("rstmid_nonseq", {30'd0, HTRANS}, 32'd2);
        @(negedge HCLK);
        HREADY = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        chk("rstmid_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rstmid_haddr", HADDR, 32'd0);
        chk("rstmid_hsize", {29'd0, HSIZE}, 32'd2);
        acks = 0;
        repeat (3) begin
            @(negedge HCLK);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; HREADY = 1'b1;
        HRESETn = 1'b1;
        acks += int'(wbs_ack_o);
        chk("rstmid_no_ack", acks, 0);
        last_rd = '0;
        chk("rstmid_dat_o", wbs_dat_o, 32'd0);
        apply_vec(tbl[1], "post_rst");

        // WB cycle dropped during the data phase of a write.
        @(negedge HCLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h0000_0050; wbs_dat_i = 32'h1111_2222; HREADY = 1'b1;
        @(negedge HCLK);
        chk("abort_nonseq", {30'd0, HTRANS}, 32'd2);
        @(negedge HCLK);
        chk("abort_hwdata", HWDATA, 32'h1111_2222);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; HREADY = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b1;
        acks = int'(wbs_ack_o); ns = 0;
        repeat (5) begin
            @(negedge HCLK);
            if (wbs_ack_o) acks++;
            if (HTRANS != 2'b00) ns++;
        end
        chk("abort_no_ack", acks, 0);
        chk("abort_no_retry", ns, 0);
        chk("abort_dat_o", wbs_dat_o, last_rd);
        apply_vec(tbl[5], "post_abort");

`ifdef WB_AHBL_TIMEOUT_EN
        // HREADY stuck low: four low cycles trip the timeout, ack carries DEADBEEF.
        @(negedge HCLK);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'h0000_0060; HREADY = 1'b0;
        acks = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge HCLK);
            if (wbs_ack_o) begin
                acks = n;
                break;
            end
        end
        chk("tmo_ack_cycle", acks, 5);
        chk("tmo_dat_o", wbs_dat_o, 32'hDEAD_BEEF);
        chk("tmo_flag", {31'd0, timeout_o}, 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; HREADY = 1'b1;
        last_rd = 32'hDEAD_BEEF;
        apply_vec(tbl[0], "post_tmo");
        chk("tmo_sticky", {31'd0, timeout_o}, 32'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("tmo_cleared", {31'd0, timeout_o}, 32'd0);
        HRESETn = 1'b1;
        last_rd = '0;
`endif

        // Random transfers against the reference model.
        for (int i = 0; i < 30; i++) begin
            v.we   = 1'($urandom);
            v.sel  = 4'($urandom_range(0, 15));
            v.adr  = $urandom;
            v.dat  = $urandom;
            v.rdat = $urandom;
            v.wa   = $urandom_range(0, 2);
            v.wd   = $urandom_range(0, 2);
            ref_map(v.sel, v.adr, a, s);
            v.e_haddr = a;
            v.e_hsize = s;
            v.e_ack   = 3 + v.wa + v.wd;
            apply_vec(v, $sformatf("rnd%0d", i));
        end

        chk("htrans_legal", bad_htrans, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
